// File: rtl/lvds_frame_tx_if.sv
// Host-side word handshake for lvds_frame_tx.
// The host drives a parallel word with a valid flag; the block answers with ready.
interface lvds_frame_tx_if #(
    parameter int WORD_BITS = 12
);
    logic [WORD_BITS-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/lvds_frame_tx.sv
// LVDS frame transmitter.
// Serialises host words MSB first, one bit per host_clk, alongside a frame clock
// that is high for the first half of every WORD_BITS-cycle frame. A one-entry
// holding register decouples the host from the frame boundary; when no word is
// available at a boundary the IDLE_WORD is sent and underrun pulses once.
// All serial outputs are registered so that no input reaches them combinationally.
module lvds_frame_tx #(
    parameter int                   WORD_BITS = 12,
    parameter logic [WORD_BITS-1:0] IDLE_WORD = '0
) (
    input  logic                 host_clk,
    input  logic                 rst_n,
    input  logic                 enable,
    lvds_frame_tx_if.slave       s_if,
    output logic                 lvds_fclk,
    output logic                 lvds_sdata,
    output logic                 busy,
    output logic                 underrun,
    output logic [15:0]          frame_count
);

    localparam int             CNT_W = $clog2(WORD_BITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_BITS - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(WORD_BITS / 2);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_BITS-1:0] hold_q, hold_d;
    logic                 holdValid_q, holdValid_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic                 fclk_q, fclk_d;
    logic                 sdata_q, sdata_d;
    logic                 underrun_q, underrun_d;
    logic [15:0]          frameCount_q, frameCount_d;

    logic                 load;
    logic                 sReady;
    logic                 xfer;
    logic [WORD_BITS-1:0] newWord;
    logic [CNT_W-1:0]     nextCnt;

    // State and datapath registers; reset discards any partial frame and held word.
    always_ff @(posedge host_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hold_q       <= '0;
            holdValid_q  <= 1'b0;
            shift_q      <= '0;
            fclk_q       <= 1'b0;
            sdata_q      <= 1'b0;
            underrun_q   <= 1'b0;
            frameCount_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            holdValid_q  <= holdValid_d;
            shift_q      <= shift_d;
            fclk_q       <= fclk_d;
            sdata_q      <= sdata_d;
            underrun_q   <= underrun_d;
            frameCount_q <= frameCount_d;
        end
    end

    // Next-state logic: frame boundary loads, hold register handshake and serialisation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        holdValid_d  = holdValid_q;
        shift_d      = shift_q;
        fclk_d       = 1'b0;
        sdata_d      = 1'b0;
        underrun_d   = 1'b0;
        frameCount_d = frameCount_q;
        newWord      = IDLE_WORD;
        nextCnt      = cnt_q + CNT_W'(1);

        // A new frame begins either straight out of IDLE or right after the last bit,
        // and only while framing is enabled, so frames are never truncated.
        load   = enable && ((state_q == IDLE) || ((state_q == RUN) && (cnt_q == LAST)));
        sReady = !holdValid_q || load;
        xfer   = s_if.s_valid && sReady;

        if ((state_q == RUN) && (cnt_q == '0)) begin
            frameCount_d = frameCount_q + 16'd1;
        end

        // The held word always goes out before a freshly offered one; with nothing
        // held, a same-cycle offer bypasses the hold register.
        if (load) begin
            if (holdValid_q) begin
                newWord     = hold_q;
                holdValid_d = xfer;
                if (xfer) begin
                    hold_d = s_if.s_data;
                end
            end else if (xfer) begin
                newWord = s_if.s_data;
            end else begin
                newWord    = IDLE_WORD;
                underrun_d = 1'b1;
            end
        end else if (xfer) begin
            hold_d      = s_if.s_data;
            holdValid_d = 1'b1;
        end

        // The output register presents bit 0 of the new frame on the cycle after the
        // load, so the shift register keeps only the bits still to be sent.
        if (load) begin
            state_d = RUN;
            cnt_d   = '0;
            shift_d = newWord << 1;
            sdata_d = newWord[WORD_BITS-1];
            fclk_d  = 1'b1;
        end else if (state_q == RUN) begin
            if (cnt_q == LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
                shift_d = '0;
            end else begin
                cnt_d   = nextCnt;
                shift_d = shift_q << 1;
                sdata_d = shift_q[WORD_BITS-1];
                fclk_d  = (nextCnt < HALF);
            end
        end
    end

    assign s_if.s_ready = sReady;
    assign lvds_fclk    = fclk_q;
    assign lvds_sdata   = sdata_q;
    assign busy         = (state_q == RUN);
    assign underrun     = underrun_q;
    assign frame_count  = frameCount_q;

endmodule

// File: tb/tb_lvds_frame_tx.sv
// Scoreboard bench for lvds_frame_tx.
// The driver issues stimulus and, from a frame-level model of the buffering
// rules, queues the word and underrun flag each frame must carry; an independent
// monitor deserialises the LVDS outputs and compares every completed frame.
module tb_lvds_frame_tx;

    localparam int             W       = 12;
    localparam logic [W-1:0]   IDLE_W  = 12'h5A3;
    localparam logic [W-1:0]   FCLK_PAT = {{(W/2){1'b1}}, {(W/2){1'b0}}};

    typedef struct {
        logic [W-1:0] word;
        bit           und;
    } frame_t;

    logic        host_clk;
    logic        rst_n;
    logic        enable;
    logic        lvds_fclk;
    logic        lvds_sdata;
    logic        busy;
    logic        underrun;
    logic [15:0] frame_count;

    lvds_frame_tx_if #(.WORD_BITS(W)) sIf ();

    lvds_frame_tx #(
        .WORD_BITS (W),
        .IDLE_WORD (IDLE_W)
    ) dut (
        .host_clk    (host_clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .s_if        (sIf.slave),
        .lvds_fclk   (lvds_fclk),
        .lvds_sdata  (lvds_sdata),
        .busy        (busy),
        .underrun    (underrun),
        .frame_count (frame_count)
    );

    int           errors = 0;
    int           checks = 0;

    frame_t       expQ[$];
    logic [W-1:0] pendQ[$];
    bit           mRun = 0;
    int           mPos = 0;

    int           bitIdx = 0;
    int           frameSeen = 0;
    logic [W-1:0] got;
    logic [W-1:0] fMask;
    bit           und0;

    // Free-running host clock.
    initial begin
        host_clk = 1'b0;
        forever #4 host_clk = ~host_clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One host cycle: drive inputs, check s_ready, and update the frame-level model.
    task automatic applyStimulus(input bit en, input bit vld, input logic [W-1:0] data, output bit accepted);
        bit     atBoundary;
        bit     expReady;
        bit     xfer;
        frame_t f;
        @(posedge host_clk);
        #1;
        enable       = en;
        sIf.s_valid  = vld;
        sIf.s_data   = data;
        #1;
        atBoundary = en && (!mRun || (mPos == W - 1));
        expReady   = (pendQ.size() == 0) || atBoundary;
        checkOutput("s_ready", {31'd0, sIf.s_ready}, {31'd0, expReady});
        xfer     = vld && expReady;
        accepted = xfer;
        if (atBoundary) begin
            if (pendQ.size() > 0) begin
                f.word = pendQ.pop_front();
                f.und  = 1'b0;
                if (xfer) pendQ.push_back(data);
            end else if (xfer) begin
                f.word = data;
                f.und  = 1'b0;
            end else begin
                f.word = IDLE_W;
                f.und  = 1'b1;
            end
            expQ.push_back(f);
        end else if (xfer) begin
            pendQ.push_back(data);
        end
        if (mRun) begin
            if (mPos == W - 1) begin
                mPos = 0;
                if (!en) mRun = 0;
            end else begin
                mPos++;
            end
        end else if (en) begin
            mRun = 1;
            mPos = 0;
        end
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic doReset();
        @(posedge host_clk);
        #1;
        rst_n       = 1'b0;
        enable      = 1'b0;
        sIf.s_valid = 1'b0;
        #1;
        checkOutput("reset_now_outputs", {28'd0, busy, lvds_fclk, lvds_sdata, underrun}, 32'd0);
        checkOutput("reset_now_frame_count", {16'd0, frame_count}, 32'd0);
        mRun = 0;
        mPos = 0;
        pendQ.delete();
        expQ.delete();
        repeat (2) @(posedge host_clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: deserialise frames on the falling edge and score them against the queue.
    always @(negedge host_clk) begin
        if (!rst_n) begin
            bitIdx    = 0;
            frameSeen = 0;
            checkOutput("reset_outputs", {28'd0, busy, lvds_fclk, lvds_sdata, underrun}, 32'd0);
            checkOutput("reset_frame_count", {16'd0, frame_count}, 32'd0);
        end else if (busy) begin
            if (bitIdx == 0) begin
                got   = '0;
                fMask = '0;
                und0  = underrun;
            end else begin
                checkOutput("underrun_mid_frame", {31'd0, underrun}, 32'd0);
            end
            got   = {got[W-2:0], lvds_sdata};
            fMask = {fMask[W-2:0], lvds_fclk};
            if (bitIdx == W - 1) begin
                frame_t f;
                frameSeen++;
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL frame_unexpected: got word %0h with no frame expected", got);
                end else begin
                    f = expQ.pop_front();
                    checkOutput("frame_word", {20'd0, got}, {20'd0, f.word});
                    checkOutput("frame_underrun", {31'd0, und0}, {31'd0, f.und});
                    checkOutput("frame_fclk", {20'd0, fMask}, {20'd0, FCLK_PAT});
                    checkOutput("frame_count", {16'd0, frame_count}, {16'd0, 16'(frameSeen)});
                end
                bitIdx = 0;
            end else begin
                bitIdx++;
            end
        end else begin
            checkOutput("idle_outputs", {29'd0, lvds_fclk, lvds_sdata, underrun}, 32'd0);
            checkOutput("frame_truncated", bitIdx, 0);
            bitIdx = 0;
        end
    end

    // Directed scenarios followed by a randomized soak.
    initial begin
        bit           acc;
        int           idx;
        int           guard;
        logic [W-1:0] words [3];

        rst_n       = 1'b0;
        enable      = 1'b0;
        sIf.s_valid = 1'b0;
        sIf.s_data  = '0;
        repeat (3) @(posedge host_clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, acc);

        // Constant word 12'h100 with valid held high.
        for (int i = 0; i < 4 * W; i++) applyStimulus(1, 1, 12'h100, acc);

        // Three words offered back-to-back.
        words[0] = 12'h7F0;
        words[1] = 12'hA0F;
        words[2] = 12'hFFF;
        idx   = 0;
        guard = 0;
        while (idx < 3 && guard < 10 * W) begin
            applyStimulus(1, 1, words[idx], acc);
            if (acc) idx++;
            guard++;
        end
        checkOutput("burst_accepted", idx, 3);

        // No host words: idle-word frames with underrun.
        for (int i = 0; i < 4 * W; i++) applyStimulus(1, 0, '0, acc);

        // Word arrives one cycle after a boundary load.
        guard = 0;
        while (!(mRun && mPos == W - 1) && guard < 2 * W) begin
            applyStimulus(1, 0, '0, acc);
            guard++;
        end
        applyStimulus(1, 0, '0, acc);
        applyStimulus(1, 1, 12'h3C5, acc);
        checkOutput("late_word_accepted", {31'd0, acc}, 32'd1);
        for (int i = 0; i < 3 * W; i++) applyStimulus(1, 0, '0, acc);

        // Enable drops at bit 3 while a word is offered; it waits in hold.
        guard = 0;
        while (!(mRun && mPos == 3) && guard < 2 * W) begin
            applyStimulus(1, 0, '0, acc);
            guard++;
        end
        applyStimulus(0, 1, 12'h6B2, acc);
        checkOutput("held_word_accepted", {31'd0, acc}, 32'd1);
        for (int i = 0; i < 2 * W; i++) applyStimulus(0, 1, 12'h111, acc);
        for (int i = 0; i < 3 * W; i++) applyStimulus(1, 0, '0, acc);

        // Reset at bit 7 with a word held; it must never appear afterwards.
        guard = 0;
        while (!(mRun && mPos == 7 && pendQ.size() > 0) && guard < 4 * W) begin
            applyStimulus(1, 1, 12'h9E4, acc);
            guard++;
        end
        doReset();
        for (int i = 0; i < 3 * W; i++) applyStimulus(1, 0, '0, acc);

        // Randomized soak with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
                              W'($urandom), acc);
            end
        end

        // Drain: stop at the next boundary and let the monitor score the last frame.
        guard = 0;
        while (mRun && guard < 2 * W) begin
            applyStimulus(0, 0, '0, acc);
            guard++;
        end
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, acc);
        checkOutput("drain_pending_frames", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lvds_frame_tx.md
LVDS_FRAME_TX -- requirements
Module: lvds_frame_tx

Interface
REQ-001 Parameter WORD_BITS, default 12: bits per frame; must be even and at least 4.
REQ-002 Parameter IDLE_WORD, default 12'h000: word sent when no host word is pending.
REQ-003 host_clk  in  1  sole clock, 120 MHz nominal; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 enable  in  1  level; 1 = run framing; 0 = stop at the next frame boundary.
REQ-006 s_data  in  WORD_BITS  parallel word to transmit.
REQ-007 s_valid  in  1  s_data is valid.
REQ-008 s_ready  out  1  block accepts s_data this cycle.
REQ-009 lvds_fclk  out  1  frame clock; period WORD_BITS cycles; high for the first WORD_BITS/2 cycles of each frame.
REQ-010 lvds_sdata  out  1  serial data, MSB first, one bit per host_clk.
REQ-011 busy  out  1  high while in RUN.
REQ-012 underrun  out  1  one-cycle pulse when IDLE_WORD is substituted.
REQ-013 frame_count  out  16  count of frames started; wraps.

Function
REQ-014 The block has two states: IDLE and RUN.
REQ-015 The block has a one-entry holding register (hold, hold_valid) and a WORD_BITS shift register.
REQ-016 Bit counter cnt counts 0..WORD_BITS-1 in RUN and wraps to 0; it is held at 0 in IDLE.
REQ-017 s_ready = !hold_valid OR load, where load = (IDLE and enable) OR (RUN and cnt==WORD_BITS-1 and enable).
REQ-018 A transfer occurs when s_valid and s_ready are both 1 on a rising edge.
REQ-019 When load and hold_valid, the shift register takes hold and hold_valid clears; a simultaneous transfer then writes hold and sets hold_valid.
REQ-020 When load and !hold_valid, the shift register takes s_data if a transfer occurs that cycle (bypass); otherwise it takes IDLE_WORD and underrun pulses the next cycle.
REQ-021 IDLE -> RUN on enable=1; the next cycle is frame bit 0.
REQ-022 RUN -> IDLE at the cycle with cnt==WORD_BITS-1 if enable=0; a frame is never truncated.
REQ-023 Output registers are driven so that in RUN cycle cnt=c: lvds_fclk = (c < WORD_BITS/2) and lvds_sdata = word bit (WORD_BITS-1-c).
REQ-024 Frame boundaries are back-to-back: bit 0 of frame n+1 follows bit WORD_BITS-1 of frame n with no gap.
REQ-025 In IDLE, lvds_fclk=0, lvds_sdata=0, and busy=0.
REQ-026 frame_count increments by 1 on each cycle with RUN and cnt==0; 16'hFFFF wraps to 0.
REQ-027 While enable=0, hold keeps any pending word, which is sent first after re-enable.
REQ-028 While enable=0 and hold_valid=1, s_ready=0.
REQ-029 No combinational path exists from inputs to lvds_fclk, lvds_sdata, underrun, or busy.
REQ-030 s_ready is combinational from s_valid-independent state and enable only.

Reset
REQ-031 Asserting rst_n=0 immediately forces: IDLE; cnt=0; hold_valid=0; shift register=0; lvds_fclk=0; lvds_sdata=0; busy=0; underrun=0; frame_count=0.
REQ-032 Reset asserted mid-frame discards the partial frame and any held word; no completion is attempted.
REQ-033 After rst_n releases, the first frame starts no earlier than the second rising edge after enable is seen high.

Verification
REQ-034 Scenario: reset, enable=1, hold s_data=12'h100 with s_valid=1. Required: lvds_sdata per frame = 0,0,0,1,0,0,0,0,0,0,0,0; lvds_fclk high 6 cycles then low 6 cycles; frame_count increments every 12 cycles.
REQ-035 Scenario: words 12'h7F0, 12'hA0F, 12'hFFF offered back-to-back with s_valid=1. Required: three contiguous frames with the exact MSB-first bit patterns, no gap frame, and underrun never pulses.
REQ-036 Scenario: enable=1 with s_valid=0. Required: IDLE_WORD frames, with one underrun pulse per frame.
REQ-037 Scenario: a word arrives one cycle after the cnt==11 load. Required: the word is held, an IDLE_WORD frame is sent, and the word is sent in the following frame.
REQ-038 Scenario: enable drops at cnt=3. Required: the frame completes all 12 bits, busy falls after bit 11, and outputs are 0. Then enable=1 with a pending hold word: that word is sent first.
REQ-039 Scenario: rst_n pulsed low at cnt=7 with hold_valid=1. Required: outputs are 0 at once, frame_count=0, and no held word is sent after re-enable.
